// File: rtl/song_reader_if.sv
// Bus between song_reader and its neighbours: player controls,
// note ROM port and the note_counter handshake.
interface song_reader_if #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic                      play;
    logic [SONG_W-1:0]         song;
    logic                      note_done;
    logic [SONG_W+IDX_W-1:0]   rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      new_note;
    logic                      timer_clear;
    logic                      active;
    logic                      song_done;

    modport master (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note,
        output timer_clear, active, song_done
    );

    modport slave (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note,
        input  timer_clear, active, song_done
    );
endinterface

// File: rtl/song_reader.sv
// Song sequencer: walks the note ROM of the selected song and
// loads each note into the note counter, advancing on timer_done.
module song_reader #(
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [SONG_W-1:0]   song_q;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic                new_note_q;
    logic                timer_clear_q;
    logic                song_done_q;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                song_change;
    logic                advance;

    assign {rom_note, rom_dur} = bus.rom_data;
    assign song_change = (bus.song != song_q);
    assign advance     = bus.note_done & bus.play;

    assign bus.rom_addr    = {song_q, idx};
    assign bus.note        = note_q;
    assign bus.duration    = dur_q;
    assign bus.new_note    = new_note_q;
    assign bus.timer_clear = timer_clear_q;
    assign bus.song_done   = song_done_q;
    assign bus.active      = (state == PLAY) & bus.play;

    // Sequencer: song change wins over note advance and end of song.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            song_q        <= '0;
            note_q        <= '0;
            dur_q         <= '0;
            new_note_q    <= 1'b0;
            timer_clear_q <= 1'b0;
            song_done_q   <= 1'b0;
        end else begin
            new_note_q    <= 1'b0;
            timer_clear_q <= 1'b0;
            song_done_q   <= 1'b0;
            if (state != IDLE && song_change) begin
                song_q        <= bus.song;
                idx           <= '0;
                timer_clear_q <= 1'b1;
                state         <= FETCH;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.play) begin
                            song_q <= bus.song;
                            state  <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (rom_dur == '0) begin
                            song_done_q <= 1'b1;
                            idx         <= '0;
                            state       <= IDLE;
                        end else begin
                            note_q        <= rom_note;
                            dur_q         <= rom_dur;
                            new_note_q    <= 1'b1;
                            timer_clear_q <= 1'b1;
                            state         <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (advance) begin
                            if (idx == LAST_IDX) begin
                                song_done_q <= 1'b1;
                                idx         <= '0;
                                state       <= IDLE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: fixed vector table for basic playback,
// then directed and random runs against a note-level model.
module tb_song_reader;
    logic clk;
    logic rst;

    song_reader_if bus ();

    song_reader dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] rom [0:127];

    // Synchronous note ROM: data follows the address by one clock.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          r;
        bit          p;
        logic [1:0]  s;
        bit          nd;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [22:0] pk(logic [6:0] a, logic [5:0] n,
                                       logic [5:0] d, logic nn,
                                       logic tc, logic sd, logic ac);
        return {a, n, d, nn, tc, sd, ac};
    endfunction

    function automatic logic [22:0] got();
        return pk(bus.rom_addr, bus.note, bus.duration, bus.new_note,
                  bus.timer_clear, bus.song_done, bus.active);
    endfunction

    function automatic vec_t mk(bit r, bit p, logic [1:0] s, bit nd,
                                logic [22:0] e);
        vec_t v;
        v.r = r; v.p = p; v.s = s; v.nd = nd; v.exp = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", nm, g, e);
        end
    endtask

    // Model: where in the song we are and how many cycles remain
    // before the next note arrives from the ROM.
    logic [1:0] m_sq;
    logic [4:0] m_idx;
    bit         m_idle;
    int         m_gap;
    logic [5:0] m_note, m_dur;
    bit         m_nn, m_tc, m_sd;

    function automatic bit m_playing();
        return !m_idle && m_gap == 0;
    endfunction

    task automatic model(bit r, bit p, logic [1:0] s, bit nd);
        logic [11:0] w;
        m_nn = 0; m_tc = 0; m_sd = 0;
        if (r) begin
            m_sq = 0; m_idx = 0; m_idle = 1; m_gap = 0;
            m_note = 0; m_dur = 0;
        end else if (m_idle) begin
            if (p) begin
                m_sq = s; m_idle = 0; m_gap = 2;
            end
        end else if (s != m_sq) begin
            m_sq = s; m_idx = 0; m_tc = 1; m_gap = 2;
        end else if (m_gap == 2) begin
            m_gap = 1;
        end else if (m_gap == 1) begin
            w = rom[{m_sq, m_idx}];
            if (w[5:0] == 0) begin
                m_sd = 1; m_idx = 0; m_idle = 1; m_gap = 0;
            end else begin
                m_note = w[11:6]; m_dur = w[5:0];
                m_nn = 1; m_tc = 1; m_gap = 0;
            end
        end else if (nd && p) begin
            if (m_idx == 31) begin
                m_sd = 1; m_idx = 0; m_idle = 1;
            end else begin
                m_idx = m_idx + 1; m_gap = 2;
            end
        end
    endtask

    task automatic step(bit r, bit p, logic [1:0] s, bit nd);
        rst = r;
        bus.play = p;
        bus.song = s;
        bus.note_done = nd;
        model(r, p, s, nd);
        @(posedge clk);
        #1;
        chk("step", {9'd0, got()},
            {9'd0, pk({m_sq, m_idx}, m_note, m_dur, m_nn, m_tc, m_sd,
                      m_playing() && p)});
    endtask

    // Plays song s until the model sits in a note at index tgt.
    task automatic advance_to(logic [1:0] s, logic [4:0] tgt);
        for (int k = 0; k < 400; k++) begin
            if (m_playing() && m_idx == tgt) return;
            step(0, 1, s, m_playing() && m_idx < tgt);
        end
        chk("advance_timeout", 0, 1);
    endtask

    initial begin
        int nn_cnt;
        int pulses;
        bit seen;
        logic [4:0] i0;
        logic [1:0] cur;

        rst = 1; bus.play = 0; bus.song = 0; bus.note_done = 0;

        for (int a = 0; a < 128; a++) begin
            logic [5:0] d;
            d = 6'($urandom_range(1, 63));
            if (a >= 96 && $urandom_range(0, 5) == 0) d = 0;
            rom[a] = {6'($urandom_range(0, 63)), d};
        end
        rom[0] = {6'd5, 6'd3};
        rom[1] = {6'd9, 6'd1};
        rom[2] = {6'd0, 6'd0};

        tbl[0]  = mk(1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(0, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        tbl[2]  = mk(0, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        tbl[3]  = mk(0, 1, 0, 0, pk(0, 5, 3, 1, 1, 0, 1));
        tbl[4]  = mk(0, 1, 0, 0, pk(0, 5, 3, 0, 0, 0, 1));
        tbl[5]  = mk(0, 1, 0, 1, pk(1, 5, 3, 0, 0, 0, 0));
        tbl[6]  = mk(0, 1, 0, 0, pk(1, 5, 3, 0, 0, 0, 0));
        tbl[7]  = mk(0, 1, 0, 0, pk(1, 9, 1, 1, 1, 0, 1));
        tbl[8]  = mk(0, 1, 0, 1, pk(2, 9, 1, 0, 0, 0, 0));
        tbl[9]  = mk(0, 1, 0, 0, pk(2, 9, 1, 0, 0, 0, 0));
        tbl[10] = mk(0, 1, 0, 0, pk(0, 9, 1, 0, 0, 1, 0));
        tbl[11] = mk(0, 1, 0, 0, pk(0, 9, 1, 0, 0, 0, 0));
        tbl[12] = mk(0, 1, 0, 0, pk(0, 9, 1, 0, 0, 0, 0));
        tbl[13] = mk(0, 1, 0, 0, pk(0, 5, 3, 1, 1, 0, 1));
        tbl[14] = mk(1, 1, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
        tbl[15] = mk(0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].r;
            bus.play = tbl[i].p;
            bus.song = tbl[i].s;
            bus.note_done = tbl[i].nd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {9'd0, got()}, {9'd0, tbl[i].exp});
        end

        // Full 32-note song without end marker, then loop restart.
        step(1, 0, 0, 0);
        nn_cnt = 0;
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step(0, 1, 1, m_playing());
            if (bus.new_note) nn_cnt++;
            if (bus.song_done) seen = 1;
        end
        chk("song1_done_seen", 32'(seen), 1);
        chk("song1_note_count", nn_cnt, 32);
        step(0, 1, 1, 0);
        chk("song1_restart_addr", 32'(bus.rom_addr), 32'h20);

        // Pause with note_done held high, then resume.
        advance_to(1, 3);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 1);
        chk("pause_active", 32'(bus.active), 0);
        chk("pause_addr", 32'(bus.rom_addr), 32'h23);
        step(0, 1, 1, 1);
        chk("resume_addr", 32'(bus.rom_addr), 32'h24);

        // Song change together with note_done at index 4.
        advance_to(1, 4);
        step(0, 1, 2, 1);
        chk("chg_addr", 32'(bus.rom_addr), 32'h40);
        chk("chg_clear", {bus.timer_clear, bus.song_done}, 32'b10);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        chk("chg_note", {bus.new_note, bus.note, bus.duration},
            {1'b1, rom[64]});

        // Reset while waiting on ROM data.
        step(1, 0, 0, 0);
        step(0, 1, 2, 0);
        step(0, 1, 2, 0);
        step(1, 1, 2, 0);
        chk("rst_wait_outs", {9'd0, got()}, 0);
        step(0, 1, 2, 0);
        chk("rst_restart_addr", 32'(bus.rom_addr), 32'h40);

        // Idle guard: no play, noisy note_done and song.
        step(1, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            pulses += bus.new_note + bus.timer_clear + bus.song_done;
        end
        chk("idle_pulses", pulses, 0);
        chk("idle_addr", 32'(bus.rom_addr), 0);

        // Random traffic.
        step(1, 0, 0, 0);
        cur = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) cur = 2'($urandom_range(0, 3));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 cur, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
